// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constant control words for the pipeline sequencer.
package pipeline_ctrl_pkg;

  // Sequencer states, 3-bit encoded.
  typedef enum logic [2:0] {
    RESET_IDLE = 3'd0,
    RUN        = 3'd1,
    DMEM_WAIT  = 3'd2,
    DRAIN      = 3'd3,
    HALTED     = 3'd4
  } pc_state_t;

  // One control word for every pipeline register plus the PC.
  typedef struct packed {
    logic en_PC;
    logic en_IF_ID;
    logic en_ID_EX;
    logic en_EX_MEM;
    logic en_MEM_WB;
    logic flush_IF_ID;
    logic flush_ID_EX;
    logic flush_EX_MEM;
  } stage_ctrl_t;

  // Normal advance: everything loads, nothing is flushed.
  localparam stage_ctrl_t CTRL_RUN    = 8'b11111_000;
  // Whole pipe held (data-memory wait, reset idle, halted).
  localparam stage_ctrl_t CTRL_FREEZE = 8'b00000_000;
  // Draining ahead of a halt: PC held, bubbles fed into IF_ID and ID_EX.
  localparam stage_ctrl_t CTRL_HALT   = 8'b01111_110;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Count up on inc unless already saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && !(&count_q)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: converts stall / redirect / memory handshakes / halt
// into per-stage load enables and bubble flushes, and keeps perf counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_stall,
  input  logic             redirect_MEM,
  input  logic             imem_ready,
  input  logic             dmem_req_MEM,
  input  logic             dmem_ready,
  input  logic             halt_ID,
  output logic             en_PC,
  output logic             en_IF_ID,
  output logic             en_ID_EX,
  output logic             en_EX_MEM,
  output logic             en_MEM_WB,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             flush_EX_MEM,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  localparam int DW = $clog2(DRAIN_CYC + 1);

  pc_state_t   state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  stage_ctrl_t ctrl;
  logic        freeze;
  logic        cyc_inc, stall_inc, flush_inc, mw_inc;

  // A data access still in flight stalls the whole machine.
  assign freeze = dmem_req_MEM & ~dmem_ready;

  // State and drain counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next-state and Mealy control outputs.
  always_comb begin
    ctrl      = CTRL_FREEZE;
    state_d   = state_q;
    drain_d   = drain_q;
    halted    = 1'b0;
    cyc_inc   = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    mw_inc    = 1'b0;
    case (state_q)
      RESET_IDLE: begin
        state_d = RUN;
      end
      RUN, DMEM_WAIT: begin
        cyc_inc = 1'b1;
        if (freeze) begin
          mw_inc  = 1'b1;
          state_d = DMEM_WAIT;
        end else begin
          state_d = RUN;
          ctrl    = CTRL_RUN;
          if (redirect_MEM) begin
            ctrl.flush_IF_ID  = 1'b1;
            ctrl.flush_ID_EX  = 1'b1;
            ctrl.flush_EX_MEM = 1'b1;
            flush_inc         = 1'b1;
          end else if (hazard_stall) begin
            ctrl.en_PC       = 1'b0;
            ctrl.en_IF_ID    = 1'b0;
            ctrl.flush_ID_EX = 1'b1;
            stall_inc        = 1'b1;
          end else if (!imem_ready) begin
            ctrl.en_PC       = 1'b0;
            ctrl.flush_IF_ID = 1'b1;
          end else if (halt_ID) begin
            // Halt sits in ID: stop fetching, let older work retire.
            ctrl.en_PC       = 1'b0;
            ctrl.flush_IF_ID = 1'b1;
            drain_d          = DW'(DRAIN_CYC);
            state_d          = DRAIN;
          end
        end
      end
      DRAIN: begin
        cyc_inc = 1'b1;
        if (freeze) begin
          mw_inc = 1'b1;
        end else if (redirect_MEM) begin
          // An older branch squashes the halt; resume normal fetch.
          ctrl              = CTRL_RUN;
          ctrl.flush_IF_ID  = 1'b1;
          ctrl.flush_ID_EX  = 1'b1;
          ctrl.flush_EX_MEM = 1'b1;
          flush_inc         = 1'b1;
          drain_d           = '0;
          state_d           = RUN;
        end else begin
          ctrl    = CTRL_HALT;
          drain_d = drain_q - 1'b1;
          if (drain_q == DW'(1)) begin
            state_d = HALTED;
          end
        end
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_d = RESET_IDLE;
      end
    endcase
  end

  assign en_PC        = ctrl.en_PC;
  assign en_IF_ID     = ctrl.en_IF_ID;
  assign en_ID_EX     = ctrl.en_ID_EX;
  assign en_EX_MEM    = ctrl.en_EX_MEM;
  assign en_MEM_WB    = ctrl.en_MEM_WB;
  assign flush_IF_ID  = ctrl.flush_IF_ID;
  assign flush_ID_EX  = ctrl.flush_ID_EX;
  assign flush_EX_MEM = ctrl.flush_EX_MEM;

  logic [3:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [4];

  assign cnt_inc = {mw_inc, flush_inc, stall_inc, cyc_inc};

  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cnt_inc[gi]),
      .count (cnt_val[gi])
    );
  end

  assign cyc_cnt     = cnt_val[0];
  assign stall_cnt   = cnt_val[1];
  assign flush_cnt   = cnt_val[2];
  assign memwait_cnt = cnt_val[3];

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central sequencer for the 5-stage MIPS pipeline. It turns the ID-stage hazard stall, the MEM-stage branch/jump redirect, the instruction- and data-memory ready handshakes and the halt instruction into per-stage enable and flush signals for the pipeline registers and PC. It also keeps saturating performance counters. It sits beside the hazard unit and drives every pipeline register.

Parameters:
CNT_W, 32, width of each performance counter
DRAIN_CYC, 3, cycles needed to retire the instructions ahead of a halt in ID_EX/EX_MEM/MEM_WB

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
hazard_stall  in  1  ID-stage RAW/control stall from the hazard unit (combinational)
redirect_MEM  in  1  taken branch/jump resolved in MEM; PC load this cycle
imem_ready  in  1  instruction fetch data valid this cycle
dmem_req_MEM  in  1  load/store present in MEM
dmem_ready  in  1  data memory completes the MEM access this cycle
halt_ID  in  1  halt/break instruction decoded in ID
en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB  out  1 each  register load enables
flush_IF_ID, flush_ID_EX, flush_EX_MEM  out  1 each  synchronous bubble insert (load NOP), effective only when the matching enable is 1
halted  out  1  core stopped
cyc_cnt, stall_cnt, flush_cnt, memwait_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset (rst_n=0, async): state=RESET_IDLE, every enable 0, every flush 0, halted 0, counters 0, drain_cnt 0. There is exactly one RESET_IDLE cycle after deassertion, then RUN.
- States: RESET_IDLE, RUN, DMEM_WAIT, DRAIN, HALTED. Outputs are combinational from state and current inputs (Mealy); state and counters are registered.
- freeze = dmem_req_MEM & ~dmem_ready. In RUN, DRAIN or DMEM_WAIT, freeze forces all en_* to 0 and all flush_* to 0. It has the highest priority. No redirect, stall or halt is acted on while frozen; those inputs must be held by the upstream stages.
- RUN, in priority order:
  - freeze: go to DMEM_WAIT.
  - redirect_MEM: all enables 1; flush_IF_ID, flush_ID_EX and flush_EX_MEM all 1.
  - hazard_stall: en_PC=0, en_IF_ID=0, en_ID_EX=1 with flush_ID_EX=1; later stages enabled.
  - ~imem_ready: en_PC=0, en_IF_ID=1 with flush_IF_ID=1; later stages enabled.
  - halt_ID: en_PC=0, flush_IF_ID=1, all other enables 1; drain_cnt=DRAIN_CYC; go to DRAIN.
  - Otherwise all enables 1 and all flushes 0.
- DMEM_WAIT: while freeze, hold all stages. On the cycle dmem_ready=1, evaluate the RUN rules with freeze=0 and return to RUN, or go to DRAIN if the halt rules select it.
- DRAIN:
  - en_PC=0, en_IF_ID=1, flush_IF_ID=1, en_ID_EX=1, flush_ID_EX=1, EX_MEM and MEM_WB enabled.
  - drain_cnt decrements by 1 each cycle that is not frozen.
  - redirect_MEM cancels the drain: the halt was younger and is squashed. Apply the RUN redirect outputs, set drain_cnt=0, go to RUN.
  - When drain_cnt==1 and the cycle is not frozen, go to HALTED.
- HALTED: all enables 0, all flushes 0, halted=1. Every input is ignored. Only reset leaves this state.
- Counters: each saturates at all-ones and never wraps.
  - cyc_cnt increments every cycle outside RESET_IDLE and HALTED.
  - stall_cnt increments on cycles where the hazard_stall rule is applied.
  - flush_cnt increments on cycles where the redirect rule is applied.
  - memwait_cnt increments on frozen cycles.

Decomposition:
- pipeline_ctrl_pkg holds:
  - the state enum pc_state_t (RESET_IDLE, RUN, DMEM_WAIT, DRAIN, HALTED, 3-bit encoded);
  - a packed stage_ctrl_t struct {en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB, flush_IF_ID, flush_ID_EX, flush_EX_MEM};
  - constants CTRL_RUN, CTRL_FREEZE, CTRL_HALT of type stage_ctrl_t.
- One sub-module, sat_counter (parameter W; inputs clk, rst_n, inc; output count), instantiated four times.

Test Plan:
- Reset release, then free-run 10 cycles with no events -> cycle 0 after release all enables 0; then all enables 1, flushes 0, cyc_cnt=10, other counters 0.
- hazard_stall=1 for 2 cycles -> en_PC=en_IF_ID=0 and flush_ID_EX=1 on both cycles, stall_cnt=2; next cycle all enables 1.
- dmem_req_MEM=1 with dmem_ready=0 for 3 cycles while redirect_MEM=1 and hazard_stall=1 -> all enables and flushes 0 for 3 cycles, memwait_cnt=3; on the ready cycle the redirect flushes (flush_cnt=1), stall_cnt unchanged.
- halt_ID pulse -> DRAIN: PC frozen and IF_ID/ID_EX flushed for 3 cycles, then halted=1 and all enables 0; inputs toggled afterwards have no effect and cyc_cnt stops.
- halt_ID, then redirect_MEM on the 2nd DRAIN cycle -> three flushes asserted, state returns to RUN, halted stays 0, en_PC=1 next cycle.
- Force cyc_cnt to all-ones (CNT_W=4 build) -> counter holds at 15. Assert rst_n=0 asynchronously mid-DRAIN -> outputs immediately reset, without waiting for a clock edge.
